// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter
//   Round-robin arbiter that shares one resource among N requesters. The
//   current owner keeps the grant while its request stays high. When HoldMax
//   is non-zero, the owner is rotated out after HoldMax consecutive cycles if
//   anyone else is waiting. All outputs are registered.
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        synchronous, active-high reset
//   enable_i       arbiter enable; low revokes any grant
//   req_i          request vector, bit i = requester i
//   grant_o        one-hot grant, all-zero when nobody owns the resource
//   grant_idx_o    binary index of the granted requester, 0 when none
//   grant_valid_o  high iff grant_o != 0
//   preempt_o      one-cycle pulse on the cycle a hold-limit rotation lands
module rr_grant_arbiter #(
    parameter int unsigned N       = 16,
    parameter int unsigned IDXW    = 4,
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            enable_i,
    input  logic [N-1:0]    req_i,
    output logic [N-1:0]    grant_o,
    output logic [IDXW-1:0] grant_idx_o,
    output logic            grant_valid_o,
    output logic            preempt_o
);

    // Hold counter only needs to reach HOLD_MAX-1.
    localparam int unsigned HoldW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HoldW-1:0] HoldLast = (HOLD_MAX != 0) ? HoldW'(HOLD_MAX - 1) : '0;

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              preempt_q, preempt_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [HoldW-1:0]  hold_q, hold_d;

    logic [N-1:0]      cand;
    logic              cand_any;
    logic [IDXW-1:0]   win;

    // First set bit of r searching start, start+1, ..., N-1, 0, ..., start-1.
    function automatic logic [IDXW-1:0] rr_pick(input logic [N-1:0]    r,
                                                input logic [IDXW-1:0] start);
        logic [IDXW-1:0] pick;
        logic            found;
        int unsigned     pos;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(start) + k;
            if (pos >= N) pos = pos - N;
            if (!found && r[pos[IDXW-1:0]]) begin
                found = 1'b1;
                pick  = pos[IDXW-1:0];
            end
        end
        return pick;
    endfunction

    // The owner is excluded from the candidate set. On release its request is
    // already low, and on a forced rotation it must not win again.
    assign cand     = req_i & ~grant_q;
    assign cand_any = |cand;
    assign win      = rr_pick(cand, ptr_q);

    always_comb begin
        logic take;
        logic drop;
        take      = 1'b0;
        drop      = 1'b0;
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        preempt_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;

        unique case (state_q)
            StIdle: begin
                if (enable_i && cand_any) take = 1'b1;
                else                      drop = 1'b1;
            end
            StOwn: begin
                if (!enable_i) begin
                    drop = 1'b1;
                end else if (!req_i[idx_q]) begin
                    // Hand straight over on release, no idle gap.
                    if (cand_any) take = 1'b1;
                    else          drop = 1'b1;
                end else if ((HOLD_MAX != 0) && (hold_q == HoldLast) && cand_any) begin
                    take      = 1'b1;
                    preempt_d = 1'b1;
                end else if (hold_q != HoldLast) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: drop = 1'b1;
        endcase

        if (take) begin
            state_d = StOwn;
            grant_d = {{(N-1){1'b0}}, 1'b1} << win;
            idx_d   = win;
            valid_d = 1'b1;
            ptr_d   = (32'(win) == N - 1) ? '0 : win + 1'b1;
            hold_d  = '0;
        end else if (drop) begin
            state_d = StIdle;
            grant_d = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            hold_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_idx_o   = idx_q;
    assign grant_valid_o = valid_q;
    assign preempt_o     = preempt_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter
//   Directed bench for rr_grant_arbiter with N=16 and HOLD_MAX=8. A table of
//   single-cycle vectors covers the basic behaviour. Looped sequences cover
//   hold-limit rotation, including the 15 -> 0 wrap, and a long sole-requester
//   stretch.
module tb_rr_grant_arbiter;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic        preempt;

    int n_vec;
    int n_err;

    rr_grant_arbiter #(
        .N        (16),
        .IDXW     (4),
        .HOLD_MAX (8)
    ) dut (
        .clk_i         (clk),
        .reset_i       (rst),
        .enable_i      (en),
        .req_i         (req),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid),
        .preempt_o     (preempt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic        rst;
        logic        en;
        logic [15:0] req;
        logic [15:0] exp_grant;
        logic [3:0]  exp_idx;
        logic        exp_valid;
        logic        exp_pre;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic r, input logic e,
                                input logic [15:0] q, input logic [15:0] g,
                                input logic [3:0] i, input logic v, input logic p);
        vec_t t;
        t.name = nm; t.rst = r; t.en = e; t.req = q;
        t.exp_grant = g; t.exp_idx = i; t.exp_valid = v; t.exp_pre = p;
        return t;
    endfunction

    // Drive inputs, let one rising edge pass, and sample 1 time unit later.
    task automatic step(input logic r, input logic e, input logic [15:0] q);
        rst = r;
        en  = e;
        req = q;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [15:0] g, input logic [3:0] i,
                         input logic v, input logic p);
        n_vec++;
        if (grant !== g || grant_idx !== i || grant_valid !== v || preempt !== p) begin
            n_err++;
            $display("FAIL %s: got grant=%h idx=%0d valid=%b preempt=%b, want grant=%h idx=%0d valid=%b preempt=%b",
                     nm, grant, grant_idx, grant_valid, preempt, g, i, v, p);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        en    = 1'b0;
        req   = '0;

        vecs.push_back(mk("rst_ffff_0", 1, 1, 16'hFFFF, 16'h0000, 0, 0, 0));
        vecs.push_back(mk("rst_ffff_1", 1, 1, 16'hFFFF, 16'h0000, 0, 0, 0));
        vecs.push_back(mk("rst_ffff_2", 1, 1, 16'hFFFF, 16'h0000, 0, 0, 0));
        vecs.push_back(mk("req14_win2", 0, 1, 16'h0014, 16'h0004, 2, 1, 0));
        vecs.push_back(mk("req14_keep2", 0, 1, 16'h0014, 16'h0004, 2, 1, 0));
        vecs.push_back(mk("release_to4", 0, 1, 16'h0010, 16'h0010, 4, 1, 0));
        vecs.push_back(mk("release_none", 0, 1, 16'h0000, 16'h0000, 0, 0, 0));
        vecs.push_back(mk("idle_en_low", 0, 0, 16'hFFFF, 16'h0000, 0, 0, 0));
        vecs.push_back(mk("ptr5_wrap_3", 0, 1, 16'h0008, 16'h0008, 3, 1, 0));
        vecs.push_back(mk("en_low_revoke", 0, 0, 16'h0008, 16'h0000, 0, 0, 0));
        vecs.push_back(mk("ptr4_req9_0", 0, 1, 16'h0009, 16'h0001, 0, 1, 0));
        vecs.push_back(mk("release_to5", 0, 1, 16'h0020, 16'h0020, 5, 1, 0));
        vecs.push_back(mk("rst_mid_grant", 1, 1, 16'h0020, 16'h0000, 0, 0, 0));
        vecs.push_back(mk("after_rst_21", 0, 1, 16'h0021, 16'h0001, 0, 1, 0));
        vecs.push_back(mk("keep0", 0, 1, 16'h0021, 16'h0001, 0, 1, 0));
        vecs.push_back(mk("release_ptr1", 0, 1, 16'h0022, 16'h0002, 1, 1, 0));
        vecs.push_back(mk("rst_again", 1, 0, 16'h0000, 16'h0000, 0, 0, 0));
        vecs.push_back(mk("ptr0_req60_5", 0, 1, 16'h0060, 16'h0020, 5, 1, 0));

        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].en, vecs[k].req);
            check(vecs[k].name, vecs[k].exp_grant, vecs[k].exp_idx,
                  vecs[k].exp_valid, vecs[k].exp_pre);
        end

        // All requesting: each owner holds 8 cycles, then rotation is forced.
        // 136 cycles run 0..15 and wrap back to owner 0.
        step(1, 1, 16'hFFFF);
        check("rot_reset", 16'h0000, 0, 0, 0);
        for (int c = 1; c <= 136; c++) begin
            int unsigned  own;
            logic [15:0]  g;
            logic         p;
            own = ((c - 1) / 8) % 16;
            g   = 16'h0001 << own;
            p   = (c > 1) && ((c - 1) % 8 == 0);
            step(0, 1, 16'hFFFF);
            check($sformatf("rot_c%0d", c), g, own[3:0], 1'b1, p);
        end

        // A sole requester is never rotated out, however long it holds.
        step(1, 1, 16'h0080);
        check("solo_reset", 16'h0000, 0, 0, 0);
        for (int c = 1; c <= 50; c++) begin
            step(0, 1, 16'h0080);
            check($sformatf("solo_c%0d", c), 16'h0080, 4'd7, 1'b1, 1'b0);
        end
        // The hold count is already saturated, so a newcomer forces an
        // immediate rotation. The search from ptr 8 wraps round to 0.
        step(0, 1, 16'h0081);
        check("solo_then_preempt", 16'h0001, 0, 1, 1);
        step(0, 1, 16'h0081);
        check("preempt_one_cycle", 16'h0001, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
